// File: rtl/pe_tile_sequencer.sv
// rtl/pe_tile_sequencer.sv - drives one PE through a clear / MAC / optional residual job.
// Buffer reads feed a two-stage pipeline to pe_en; the drain state waits out the pipeline before capturing the result.
module pe_tile_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] vec_len,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  use_residual,
    input  logic [DATA_WIDTH-1:0] residual_in,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_in_data,
    input  logic [DATA_WIDTH-1:0] mem_wt_data,
    output logic                  pe_clear,
    output logic                  pe_en,
    output logic                  pe_mode_residual,
    output logic [DATA_WIDTH-1:0] pe_input_data,
    output logic [DATA_WIDTH-1:0] pe_weight_data,
    output logic [DATA_WIDTH-1:0] pe_residual_data,
    input  logic                  pe_skipped,
    input  logic [DATA_WIDTH-1:0] pe_output_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic [15:0]           op_count,
    output logic [15:0]           skip_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FETCH = 3'd2,
        RESID = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  use_res_q, use_res_d;
    logic [DATA_WIDTH-1:0] res_val_q, res_val_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  mac_en_q, mac_en_d;
    logic                  mac_dly_q, mac_dly_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] in_data_q, in_data_d;
    logic [DATA_WIDTH-1:0] wt_data_q, wt_data_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [15:0]           op_count_q, op_count_d;
    logic [15:0]           skip_count_q, skip_count_d;

    assign mem_rd_en        = (state_q == FETCH);
    assign mem_addr         = (state_q == FETCH) ? base_q + idx_q : '0;
    assign pe_clear         = (state_q == CLEAR);
    assign pe_mode_residual = (state_q == RESID);
    assign pe_en            = mac_en_q | pe_mode_residual;
    assign pe_input_data    = pe_mode_residual ? '0 : in_data_q;
    assign pe_weight_data   = pe_mode_residual ? '0 : wt_data_q;
    assign pe_residual_data = pe_mode_residual ? res_val_q : '0;
    assign busy             = (state_q != IDLE);
    assign done             = (state_q == DONE);
    assign result           = result_q;
    assign op_count         = op_count_q;
    assign skip_count       = skip_count_q;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        base_d       = base_q;
        idx_d        = idx_q;
        use_res_d    = use_res_q;
        res_val_d    = res_val_q;
        rd_valid_d   = 1'b0;
        mac_en_d     = rd_valid_q;
        mac_dly_d    = mac_en_q;
        out_valid_d  = pe_en;
        in_data_d    = rd_valid_q ? mem_in_data : in_data_q;
        wt_data_d    = rd_valid_q ? mem_wt_data : wt_data_q;
        result_d     = result_q;
        op_count_d   = op_count_q + {15'd0, mac_en_q};
        skip_count_d = skip_count_q + {15'd0, mac_dly_q & pe_skipped};

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    len_d     = vec_len;
                    base_d    = base_addr;
                    use_res_d = use_residual;
                    res_val_d = residual_in;
                    state_d   = CLEAR;
                end
            end
            CLEAR: begin
                idx_d        = '0;
                result_d     = '0;
                op_count_d   = '0;
                skip_count_d = '0;
                if (len_q != '0) begin
                    state_d = FETCH;
                end else if (use_res_q) begin
                    state_d = RESID;
                end else begin
                    state_d = DONE;
                end
            end
            FETCH: begin
                rd_valid_d = 1'b1;
                idx_d      = idx_q + ADDR_ONE;
                if (idx_q == len_q - ADDR_ONE) begin
                    state_d = DRAIN;
                end
            end
            RESID: begin
                state_d = DRAIN;
            end
            DRAIN: begin
                // Still-pending reads keep us here; the last MAC cycle decides whether a residual step follows.
                if (rd_valid_q) begin
                    state_d = DRAIN;
                end else if (mac_en_q) begin
                    state_d = use_res_q ? RESID : DRAIN;
                end else begin
                    result_d = pe_output_data;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort flushes the pipeline and freezes the reported job state.
        if (abort && state_q != IDLE) begin
            state_d      = IDLE;
            rd_valid_d   = 1'b0;
            mac_en_d     = 1'b0;
            mac_dly_d    = 1'b0;
            out_valid_d  = 1'b0;
            result_d     = result_q;
            op_count_d   = op_count_q;
            skip_count_d = skip_count_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            base_q       <= '0;
            idx_q        <= '0;
            use_res_q    <= 1'b0;
            res_val_q    <= '0;
            rd_valid_q   <= 1'b0;
            mac_en_q     <= 1'b0;
            mac_dly_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            in_data_q    <= '0;
            wt_data_q    <= '0;
            result_q     <= '0;
            op_count_q   <= '0;
            skip_count_q <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            base_q       <= base_d;
            idx_q        <= idx_d;
            use_res_q    <= use_res_d;
            res_val_q    <= res_val_d;
            rd_valid_q   <= rd_valid_d;
            mac_en_q     <= mac_en_d;
            mac_dly_q    <= mac_dly_d;
            out_valid_q  <= out_valid_d;
            in_data_q    <= in_data_d;
            wt_data_q    <= wt_data_d;
            result_q     <= result_d;
            op_count_q   <= op_count_d;
            skip_count_q <= skip_count_d;
        end
    end

endmodule

// File: tb/tb_pe_tile_sequencer.sv
// tb/tb_pe_tile_sequencer.sv - directed vector bench for pe_tile_sequencer with buffer and PE stubs.
module tb_pe_tile_sequencer;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int NC = 16;

    logic          clk = 1'b0;
    logic          rst, start, abort, use_residual;
    logic [AW-1:0] vec_len, base_addr, mem_addr;
    logic [DW-1:0] residual_in, mem_in_data, mem_wt_data;
    logic          mem_rd_en, pe_clear, pe_en, pe_mode_residual, pe_skipped, busy, done;
    logic [DW-1:0] pe_input_data, pe_weight_data, pe_residual_data, pe_output_data, result;
    logic [15:0]   op_count, skip_count;

    always #5 clk = ~clk;

    pe_tile_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .vec_len(vec_len), .base_addr(base_addr), .use_residual(use_residual),
        .residual_in(residual_in), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_in_data(mem_in_data), .mem_wt_data(mem_wt_data), .pe_clear(pe_clear),
        .pe_en(pe_en), .pe_mode_residual(pe_mode_residual), .pe_input_data(pe_input_data),
        .pe_weight_data(pe_weight_data), .pe_residual_data(pe_residual_data),
        .pe_skipped(pe_skipped), .pe_output_data(pe_output_data), .busy(busy),
        .done(done), .result(result), .op_count(op_count), .skip_count(skip_count)
    );

    typedef struct {
        int len; int base; int use_res; int resid; int mask;
        int abort_c; int start2_c;
        int e_done; int e_result; int e_op; int e_skip;
    } vec_t;

    logic          l_busy [NC];
    logic          l_done [NC];
    logic          l_rd   [NC];
    logic          l_en   [NC];
    logic          l_mode [NC];
    logic          l_clr  [NC];
    logic [AW-1:0] l_addr [NC];
    logic [DW-1:0] l_res  [NC];
    logic [DW-1:0] l_in   [NC];
    logic [DW-1:0] l_resd [NC];
    logic [15:0]   l_op   [NC];
    logic [15:0]   l_skip [NC];

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] acc = '0;
    int            mac_idx;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
        end
    endtask

    // Runs NC cycles from cycle 0 (start), logging outputs at each negedge and answering as buffer and PE.
    task automatic run_job(input int len, input int base, input int use_res, input int resid,
                           input int mask, input int abort_c, input int start2_c, input int rst_c);
        logic          s_rd, s_en, s_mode, s_clr;
        logic [AW-1:0] s_addr, a1;
        logic [DW-1:0] s_in, s_wt, s_resd;
        mac_idx      = 0;
        vec_len      = len[AW-1:0];
        base_addr    = base[AW-1:0];
        use_residual = use_res[0];
        residual_in  = resid[DW-1:0];
        for (int c = 0; c < NC; c++) begin
            start = (c == 0) || (c == start2_c);
            abort = (c == abort_c);
            rst   = (c == rst_c);
            @(negedge clk);
            l_busy[c] = busy;       l_done[c] = done;     l_rd[c]   = mem_rd_en;
            l_en[c]   = pe_en;      l_mode[c] = pe_mode_residual;
            l_clr[c]  = pe_clear;   l_addr[c] = mem_addr; l_res[c]  = result;
            l_in[c]   = pe_input_data; l_resd[c] = pe_residual_data;
            l_op[c]   = op_count;   l_skip[c] = skip_count;
            s_rd = mem_rd_en; s_addr = mem_addr; s_en = pe_en; s_mode = pe_mode_residual;
            s_clr = pe_clear; s_in = pe_input_data; s_wt = pe_weight_data; s_resd = pe_residual_data;
            @(posedge clk);
            #1;
            a1          = s_addr + 8'd1;
            mem_in_data = s_rd ? {8'h00, a1} : 16'hBAD0;
            mem_wt_data = s_rd ? 16'd2 : 16'h0BAD;
            pe_skipped  = 1'b0;
            if (s_clr) acc = '0;
            if (s_en) begin
                if (s_mode) begin
                    acc = acc + s_resd;
                end else begin
                    acc        = acc + s_in * s_wt;
                    pe_skipped = mask[mac_idx];
                    mac_idx++;
                end
            end
            pe_output_data = acc;
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
    endtask

    vec_t vt [9];

    initial begin
        int dc, fd, bc, rc;
        //          len  base  res rv  mask  abrt st2 done result op skip
        vt[0] = '{4, 'h10, 0, 0, 'b0000, -1, -1, 9, 148, 4, 0};
        vt[1] = '{4, 'h10, 0, 0, 'b0101, -1,  9, 9, 148, 4, 2};
        vt[2] = '{2, 'h20, 1, 5, 'b0000, -1, -1, 8, 139, 2, 0};
        vt[3] = '{4, 'hFE, 0, 0, 'b0000, -1, -1, 9, 516, 4, 0};
        vt[4] = '{0, 'h30, 0, 0, 'b0000, -1, -1, 2,   0, 0, 0};
        vt[5] = '{0, 'h30, 1, 7, 'b0000, -1, -1, 4,   7, 0, 0};
        vt[6] = '{1, 'h00, 0, 0, 'b0001, -1, -1, 6,   2, 1, 1};
        vt[7] = '{8, 'h40, 0, 0, 'b0000,  5,  3, -1,  0, 0, 0};
        vt[8] = '{4, 'h10, 0, 0, 'b0000,  0, -1, -1,  0, 0, 0};

        rst = 1'b1; start = 1'b0; abort = 1'b0; vec_len = '0; base_addr = '0;
        use_residual = 1'b0; residual_in = '0; mem_in_data = '0; mem_wt_data = '0;
        pe_skipped = 1'b0; pe_output_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_pe_en", int'(pe_en), 0);
        chk("reset_result", int'(result), 0);
        chk("reset_op_count", int'(op_count), 0);
        @(posedge clk);
        #1;

        // Reset mid-job: everything drops to zero the cycle after rst.
        run_job(4, 'h10, 0, 0, 0, -1, -1, 6);
        chk("midrst_op_before", int'(l_op[6]), 2);
        chk("midrst_busy", int'(l_busy[7]), 0);
        chk("midrst_done", int'(l_done[7]), 0);
        chk("midrst_pe_en", int'(l_en[7]), 0);
        chk("midrst_rd_en", int'(l_rd[7]), 0);
        chk("midrst_addr", int'(l_addr[7]), 0);
        chk("midrst_result", int'(l_res[7]), 0);
        chk("midrst_op_count", int'(l_op[7]), 0);
        chk("midrst_in_data", int'(l_in[7]), 0);

        for (int v = 0; v < 9; v++) begin
            run_job(vt[v].len, vt[v].base, vt[v].use_res, vt[v].resid, vt[v].mask,
                    vt[v].abort_c, vt[v].start2_c, -1);
            dc = 0; fd = -1; bc = 0;
            for (int c = 0; c < NC; c++) begin
                if (l_done[c]) begin
                    dc++;
                    if (fd < 0) fd = c;
                end
                if (l_busy[c]) bc++;
            end
            if (vt[v].e_done >= 0) begin
                chk($sformatf("v%0d_done_cycle", v), fd, vt[v].e_done);
                chk($sformatf("v%0d_done_pulses", v), dc, 1);
                chk($sformatf("v%0d_busy_cycles", v), bc, vt[v].e_done);
                chk($sformatf("v%0d_busy_first", v), int'(l_busy[1]), 1);
                chk($sformatf("v%0d_clear", v), int'(l_clr[1]), 1);
                chk($sformatf("v%0d_result", v), int'(l_res[vt[v].e_done]), vt[v].e_result);
                chk($sformatf("v%0d_op_count", v), int'(l_op[vt[v].e_done]), vt[v].e_op);
                chk($sformatf("v%0d_skip_count", v), int'(l_skip[vt[v].e_done]), vt[v].e_skip);
                chk($sformatf("v%0d_result_hold", v), int'(l_res[vt[v].e_done + 3]), vt[v].e_result);
                for (int k = 0; k < vt[v].len; k++) begin
                    chk($sformatf("v%0d_rd_en_%0d", v, k), int'(l_rd[2 + k]), 1);
                    chk($sformatf("v%0d_addr_%0d", v, k), int'(l_addr[2 + k]), (vt[v].base + k) % 256);
                    chk($sformatf("v%0d_pe_en_%0d", v, k), int'(l_en[4 + k]), 1);
                    chk($sformatf("v%0d_mode_%0d", v, k), int'(l_mode[4 + k]), 0);
                end
                chk($sformatf("v%0d_rd_end", v), int'(l_rd[2 + vt[v].len]), 0);
                if (vt[v].use_res != 0) begin
                    rc = (vt[v].len > 0) ? vt[v].len + 4 : 2;
                    chk($sformatf("v%0d_res_en", v), int'(l_en[rc]), 1);
                    chk($sformatf("v%0d_res_mode", v), int'(l_mode[rc]), 1);
                    chk($sformatf("v%0d_res_data", v), int'(l_resd[rc]), vt[v].resid);
                    chk($sformatf("v%0d_res_in_zero", v), int'(l_in[rc]), 0);
                end else begin
                    chk($sformatf("v%0d_no_res_mode", v), int'(l_mode[vt[v].e_done - 1]), 0);
                end
            end else begin
                chk($sformatf("v%0d_no_done", v), dc, 0);
                chk($sformatf("v%0d_abort_busy", v), int'(l_busy[vt[v].abort_c + 1]), 0);
                chk($sformatf("v%0d_abort_pe_en", v), int'(l_en[vt[v].abort_c + 1]), 0);
                chk($sformatf("v%0d_abort_rd_en", v), int'(l_rd[vt[v].abort_c + 1]), 0);
                chk($sformatf("v%0d_abort_clear", v), int'(l_clr[vt[v].abort_c + 1]), 0);
                chk($sformatf("v%0d_idle_after", v), int'(l_busy[NC - 1]), 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pe_tile_sequencer.md
PE_TILE_SEQUENCER -- requirements
Module: pe_tile_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the operand, residual and result width.
REQ-002 Parameter ADDR_WIDTH, default 8, SHALL set the operand-buffer address and vector-length width.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 Ports (name  direction  width  meaning):
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  job request; sampled only in IDLE
abort  in  1  cancels the current job
vec_len  in  ADDR_WIDTH  MAC element count; sampled with start
base_addr  in  ADDR_WIDTH  first buffer address; sampled with start
use_residual  in  1  append a residual-add step; sampled with start
residual_in  in  DATA_WIDTH  residual value; sampled with start
mem_rd_en  out  1  buffer read strobe
mem_addr  out  ADDR_WIDTH  shared input/weight buffer address
mem_in_data  in  DATA_WIDTH  input operand, valid 1 cycle after mem_rd_en
mem_wt_data  in  DATA_WIDTH  weight operand, valid 1 cycle after mem_rd_en
pe_clear  out  1  one-cycle accumulator clear to the PE
pe_en  out  1  PE enable
pe_mode_residual  out  1  PE residual mode
pe_input_data, pe_weight_data, pe_residual_data  out  DATA_WIDTH each  PE operands
pe_skipped  in  1  PE computation_skipped, valid 1 cycle after pe_en
pe_output_data  in  DATA_WIDTH  PE output_data, valid 1 cycle after pe_en
busy  out  1  job in progress
done  out  1  one-cycle completion pulse
result  out  DATA_WIDTH  captured PE result
op_count, skip_count  out  16 each  MAC ops issued / ops the PE skipped, current job

Function
REQ-005 The FSM SHALL use states IDLE, CLEAR, FETCH, RESID, DRAIN, DONE.
REQ-006 IDLE: when start=1 and abort=0 in cycle 0, the block SHALL latch job fields and enter CLEAR in cycle 1.
REQ-007 CLEAR: the block SHALL assert pe_clear=1, zero op_count and skip_count, and enter FETCH (vec_len>0) or, for vec_len=0, RESID (use_residual=1) or DONE.
REQ-008 FETCH: in cycles 2..N+1 (N=vec_len), the block SHALL assert mem_rd_en with mem_addr=(base_addr+k) mod 2^ADDR_WIDTH for k=0..N-1.
REQ-009 For the read issued in cycle c, the block SHALL register mem_in_data/mem_wt_data into pe_input_data/pe_weight_data and assert pe_en=1, pe_mode_residual=0 in cycle c+2; the MAC pe_en cycles are therefore 4..N+3, with no gaps.
REQ-010 op_count SHALL increment once per MAC pe_en cycle.
REQ-011 skip_count SHALL increment in the cycle after each MAC pe_en cycle in which pe_skipped=1.
REQ-012 RESID (use_residual=1): in the cycle after the last MAC pe_en cycle (cycle 2 if N=0), the block SHALL drive pe_en=1, pe_mode_residual=1, pe_residual_data=latched residual, pe_input_data=pe_weight_data=0; this cycle SHALL NOT count toward op_count or skip_count.
REQ-013 L denotes the last pe_en cycle. result SHALL capture pe_output_data in cycle L+1; done=1 SHALL be asserted in cycle L+2 with result, op_count and skip_count final; the block SHALL then return to IDLE.
REQ-014 With N=0 and use_residual=0, done SHALL be asserted in cycle 2, with result=0 and both counts 0.
REQ-015 busy SHALL be 1 from cycle 1 through the done cycle inclusive, and 0 otherwise.
REQ-016 start while not in IDLE (including the DONE cycle) SHALL be ignored.
REQ-017 abort=1 in any non-IDLE state SHALL force IDLE in the next cycle: pe_en, mem_rd_en and pe_clear deasserted, no done pulse, and result and both counts held.
REQ-018 abort=1 with start=1 in IDLE: abort SHALL win and the start SHALL be dropped.
REQ-019 pe_en, mem_rd_en, pe_clear, pe_mode_residual and done SHALL be 0 in every cycle not listed above.
REQ-020 result, op_count and skip_count SHALL hold their values until the next CLEAR.

Reset
REQ-021 rst=1 SHALL, at the next clock edge and from any state, force IDLE and clear every output and counter to 0, discarding any job in progress.

Verification
REQ-022 vec_len=4, base_addr=0x10, use_residual=0, start in cycle 0 -> mem_addr 0x10..0x13 in cycles 2-5; pe_en in cycles 4-7; done in cycle 9; op_count=4.
REQ-023 Same job, stub pe_skipped=1 after the 1st and 3rd MAC ops -> skip_count=2 at done.
REQ-024 vec_len=2, use_residual=1, residual_in=0x0005 -> MAC pe_en in cycles 4-5; cycle 6 has pe_mode_residual=1 and pe_residual_data=5; done in cycle 8; op_count=2.
REQ-025 base_addr=0xFE, vec_len=4 -> mem_addr sequence FE, FF, 00, 01.
REQ-026 abort in cycle 5 of a vec_len=8 job -> IDLE and busy=0 in cycle 6, no done; a start in cycle 3 of that job is ignored.
REQ-027 rst in cycle 6 of a job -> all outputs 0 in cycle 7; a new start afterwards completes normally.
